// File: rtl/wb_arbiter_pkg.sv
// Shared widths, source index constants and the writeback entry layout
// for the ROB writeback arbiter.
package wb_arbiter_pkg;

    localparam int unsigned WB_ECAUSE_W = 5;
    localparam int unsigned ROBID_W     = 7;
    localparam int unsigned XLEN        = 32;

    localparam int unsigned SRC_ALU = 0;
    localparam int unsigned SRC_BR  = 1;
    localparam int unsigned SRC_LSQ = 2;
    localparam int unsigned SRC_MUL = 3;

    typedef struct packed {
        logic                   error;
        logic [WB_ECAUSE_W-1:0] ecause;
        logic [ROBID_W-1:0]     robid;
        logic [XLEN-1:0]        result;
    } wb_entry_t;

    function automatic int unsigned rr_index(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Per-source skid FIFO holding completed results until the arbiter grants them.
// The full flag is a flop so it can drive src_ready directly.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      enq,
    input  wb_entry_t din,
    input  logic      deq,
    input  logic      flush,
    output logic      empty,
    output logic      full,
    output wb_entry_t head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    wb_entry_t     mem_q [DEPTH];

    logic do_enq, do_deq;

    // Enqueue is blocked on a full FIFO even if the head leaves this cycle.
    assign do_enq = enq & ~full_q;
    assign do_deq = deq & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_enq) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_deq) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_enq, do_deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        full_d = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq && !flush) mem_q[wr_ptr_q] <= din;
    end

    assign empty = (count_q == '0);
    assign full  = full_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/wb_arbiter.sv
// Serialises execution-unit completions onto the single ROB writeback port
// using per-source FIFOs and a round-robin grant over the FIFO heads.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NSRC  = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rob_flush,
    input  logic [NSRC-1:0]             src_valid,
    output logic [NSRC-1:0]             src_ready,
    input  logic [NSRC-1:0]             src_error,
    input  logic [NSRC*WB_ECAUSE_W-1:0] src_ecause,
    input  logic [NSRC*ROBID_W-1:0]     src_robid,
    input  logic [NSRC*XLEN-1:0]        src_result,
    output logic                        wb_valid,
    output logic                        wb_error,
    output logic [WB_ECAUSE_W-1:0]      wb_ecause,
    output logic [ROBID_W-1:0]          wb_robid,
    output logic [XLEN-1:0]             wb_result
);

    localparam int unsigned PW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0] empty_w, full_w, gnt_oh;
    wb_entry_t       din_w  [NSRC];
    wb_entry_t       head_w [NSRC];

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gnt_idx, cand;
    logic            gnt_valid;
    logic            wb_valid_q, wb_valid_d;
    wb_entry_t       wb_q, wb_d;

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        assign din_w[gi] = '{
            error:  src_error[gi],
            ecause: src_ecause[gi*WB_ECAUSE_W +: WB_ECAUSE_W],
            robid:  src_robid[gi*ROBID_W +: ROBID_W],
            result: src_result[gi*XLEN +: XLEN]
        };

        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .enq   (src_valid[gi] & ~rob_flush),
            .din   (din_w[gi]),
            .deq   (gnt_oh[gi]),
            .flush (rob_flush),
            .empty (empty_w[gi]),
            .full  (full_w[gi]),
            .head  (head_w[gi])
        );
    end

    assign src_ready = ~full_w;

    // First non-empty head found scanning upward from ptr, wrapping at NSRC.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            cand = PW'(rr_index(32'(ptr_q), k, NSRC));
            if (!gnt_valid && !empty_w[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        gnt_oh = '0;
        if (gnt_valid) gnt_oh[gnt_idx] = 1'b1;
    end

    always_comb begin
        ptr_d      = ptr_q;
        wb_valid_d = 1'b0;
        wb_d       = wb_q;
        if (gnt_valid && !rob_flush) begin
            ptr_d      = PW'(rr_index(32'(gnt_idx), 1, NSRC));
            wb_valid_d = 1'b1;
            wb_d       = head_w[gnt_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wb_valid_q <= wb_valid_d;
            wb_q       <= wb_d;
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_error  = wb_q.error;
    assign wb_ecause = wb_q.ecause;
    assign wb_robid  = wb_q.robid;
    assign wb_result = wb_q.result;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected beats are queued when driven and
// matched against beats captured from the writeback port.
module tb_wb_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         rob_flush;
    logic [3:0]   src_valid, src_ready, src_error;
    logic [19:0]  src_ecause;
    logic [27:0]  src_robid;
    logic [127:0] src_result;
    logic         wb_valid, wb_error;
    logic [4:0]   wb_ecause;
    logic [6:0]   wb_robid;
    logic [31:0]  wb_result;

    wb_arbiter #(.NSRC(4), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .rob_flush  (rob_flush),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_error  (src_error),
        .src_ecause (src_ecause),
        .src_robid  (src_robid),
        .src_result (src_result),
        .wb_valid   (wb_valid),
        .wb_error   (wb_error),
        .wb_ecause  (wb_ecause),
        .wb_robid   (wb_robid),
        .wb_result  (wb_result)
    );

    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    typedef struct {
        logic        err;
        logic [4:0]  ec;
        logic [6:0]  rid;
        logic [31:0] res;
        int          stamp;
    } beat_t;

    beat_t obs[$];
    beat_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // stamp = edge count at which wb_valid became visible
    always @(negedge clk)
        if (rst === 1'b1 && wb_valid === 1'b1)
            obs.push_back('{wb_error, wb_ecause, wb_robid, wb_result, ecnt});

    task automatic idle();
        src_valid = '0; src_error = '0; src_ecause = '0;
        src_robid = '0; src_result = '0; rob_flush = 1'b0;
    endtask

    task automatic set_src(input int s, input logic e, input logic [4:0] ec,
                           input logic [6:0] rid, input logic [31:0] res);
        src_valid[s]          = 1'b1;
        src_error[s]          = e;
        src_ecause[s*5 +: 5]  = ec;
        src_robid[s*7 +: 7]   = rid;
        src_result[s*32 +: 32] = res;
    endtask

    // Called at a negedge after set_src: handshake lands on the next edge,
    // beat becomes visible one edge later.
    task automatic push_exp(input int s, input int extra);
        beat_t b;
        b.err   = src_error[s];
        b.ec    = src_ecause[s*5 +: 5];
        b.rid   = src_robid[s*7 +: 7];
        b.res   = src_result[s*32 +: 32];
        b.stamp = ecnt + 2 + extra;
        exp_q.push_back(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        src_valid = 4'hF;
        src_robid = 28'h5A5A5A5;
        repeat (2) @(negedge clk);
        n_tests++; if (src_ready !== 4'hF) begin n_fail++; $display("FAIL reset_ready got=%h exp=F", src_ready); end
        n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
        n_tests++; if (wb_robid !== 7'd0) begin n_fail++; $display("FAIL reset_wb_robid got=%0d exp=0", wb_robid); end
        n_tests++; if (wb_result !== 32'd0) begin n_fail++; $display("FAIL reset_wb_result got=%h exp=0", wb_result); end
        rst = 1'b1;
        src_valid = '0;
        obs.delete();
        repeat (3) @(negedge clk);
        n_tests++; if (obs.size() !== 0) begin n_fail++; $display("FAIL reset_no_beat got=%0d beats exp=0", obs.size()); end
    endtask

    task automatic test_single();
        beat_t e, o;
        do_reset();
        @(negedge clk);
        set_src(2, 1'b0, 5'd0, 7'd5, 32'hDEAD_BEEF);
        push_exp(2, 0);
        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);
        n_tests++; if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL single_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs.pop_front();
            n_tests++;
            if (o.rid !== e.rid || o.res !== e.res || o.err !== e.err || o.stamp !== e.stamp) begin
                n_fail++;
                $display("FAIL single_beat got rid=%0d res=%h err=%b t=%0d exp rid=%0d res=%h err=%b t=%0d",
                         o.rid, o.res, o.err, o.stamp, e.rid, e.res, e.err, e.stamp);
            end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_contention();
        int order [4] = '{2, 3, 0, 1};
        beat_t e, o;
        do_reset();
        @(negedge clk);
        for (int s = 0; s < 4; s++) set_src(s, 1'b0, 5'd0, 7'(10 + s), $urandom);
        for (int s = 0; s < 4; s++) push_exp(s, s);
        @(negedge clk);
        idle();
        repeat (5) @(negedge clk);
        // lone beat on source 1 leaves the pointer at 2
        set_src(1, 1'b0, 5'd0, 7'd20, $urandom);
        push_exp(1, 0);
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) set_src(s, 1'b0, 5'd0, 7'(10 + s), $urandom);
        for (int k = 0; k < 4; k++) push_exp(order[k], k);
        @(negedge clk);
        idle();
        repeat (6) @(negedge clk);
        n_tests++; if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL contention_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs.pop_front();
            n_tests++;
            if (o.rid !== e.rid || o.res !== e.res || o.stamp !== e.stamp) begin
                n_fail++;
                $display("FAIL contention_beat got rid=%0d t=%0d exp rid=%0d t=%0d", o.rid, o.stamp, e.rid, e.stamp);
            end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        int    seq [4] = '{0, 0, 0, 0};
        int    last [4] = '{-1, -1, -1, -1};
        beat_t pool[$];
        beat_t b, o;
        int    acc0 = 0;
        bit    dropped = 1'b0;
        int    last0 = -1;
        int    idx;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            for (int s = 0; s < 4; s++) begin
                set_src(s, 1'b0, 5'(s), 7'(s*32 + seq[s]), 32'hA500_0000 | (s << 16) | seq[s]);
                if (src_ready[s] === 1'b1) begin
                    b.err = 1'b0; b.ec = 5'(s); b.rid = 7'(s*32 + seq[s]);
                    b.res = 32'hA500_0000 | (s << 16) | seq[s]; b.stamp = ecnt + 1;
                    pool.push_back(b);
                    seq[s]++;
                    if (s == 0 && !dropped) acc0++;
                end else if (s == 0) begin
                    dropped = 1'b1;
                end
            end
        end
        @(negedge clk);
        idle();
        repeat (20) @(negedge clk);
        n_tests++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL bp_ready_drop got=%b exp=1", dropped); end
        n_tests++; if (acc0 < 2) begin n_fail++; $display("FAIL bp_accept_before_full got=%0d exp>=2", acc0); end
        while (obs.size() > 0) begin
            o = obs.pop_front();
            idx = -1;
            foreach (pool[i]) if (idx < 0 && pool[i].rid === o.rid) idx = i;
            n_tests++;
            if (idx < 0) begin
                n_fail++;
                $display("FAIL bp_unknown_or_dup got rid=%0d exp=rid pending", o.rid);
            end else if (o.res !== pool[idx].res || o.ec !== pool[idx].ec ||
                         int'(o.rid % 32) <= last[o.rid / 32]) begin
                n_fail++;
                $display("FAIL bp_beat got rid=%0d res=%h ec=%0d exp res=%h ec=%0d after seq %0d",
                         o.rid, o.res, o.ec, pool[idx].res, pool[idx].ec, last[o.rid / 32]);
            end
            if (idx >= 0) begin
                last[o.rid / 32] = int'(o.rid % 32);
                pool.delete(idx);
            end
            if (o.rid < 32) begin
                if (last0 >= 0) begin
                    n_tests++;
                    if (o.stamp - last0 > 4) begin
                        n_fail++;
                        $display("FAIL bp_fairness got gap=%0d exp<=4", o.stamp - last0);
                    end
                end
                last0 = o.stamp;
            end
        end
        n_tests++; if (pool.size() !== 0) begin n_fail++; $display("FAIL bp_lost got=%0d undelivered exp=0", pool.size()); end
    endtask

    task automatic test_flush();
        int    seq [4] = '{0, 0, 0, 0};
        int    fedge;
        beat_t e, o;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int s = 0; s < 4; s++) begin
                set_src(s, 1'b0, 5'd0, 7'(64 + s*8 + seq[s]), $urandom);
                if (src_ready[s] === 1'b1) seq[s]++;
            end
        end
        @(negedge clk);
        for (int s = 0; s < 4; s++) set_src(s, 1'b0, 5'd0, 7'(100 + s), $urandom);
        rob_flush = 1'b1;
        fedge = ecnt + 1;
        @(negedge clk);
        idle();
        n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wb_valid got=%b exp=0", wb_valid); end
        n_tests++; if (src_ready !== 4'hF) begin n_fail++; $display("FAIL flush_ready got=%h exp=F", src_ready); end
        repeat (5) @(negedge clk);
        n_tests++; if (obs.size() !== 2) begin n_fail++; $display("FAIL flush_pre_beats got=%0d exp=2", obs.size()); end
        while (obs.size() > 0) begin
            o = obs.pop_front();
            n_tests++;
            if (o.stamp >= fedge || o.rid < 7'd64 || o.rid >= 7'd96) begin
                n_fail++;
                $display("FAIL flush_leak got rid=%0d t=%0d exp=pre-flush beat before t=%0d", o.rid, o.stamp, fedge);
            end
        end
        // pointer sits at 2 across the flush, so source 2 wins over source 0
        @(negedge clk);
        set_src(0, 1'b0, 5'd0, 7'd40, $urandom);
        set_src(2, 1'b0, 5'd0, 7'd42, $urandom);
        push_exp(2, 0);
        push_exp(0, 1);
        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);
        n_tests++; if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL flush_after_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs.pop_front();
            n_tests++;
            if (o.rid !== e.rid || o.res !== e.res || o.stamp !== e.stamp) begin
                n_fail++;
                $display("FAIL flush_after_beat got rid=%0d t=%0d exp rid=%0d t=%0d", o.rid, o.stamp, e.rid, e.stamp);
            end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_error();
        beat_t e, o;
        @(negedge clk);
        obs.delete(); exp_q.delete();
        set_src(1, 1'b1, 5'd2, 7'd127, $urandom);
        push_exp(1, 0);
        @(negedge clk);
        idle();
        set_src(3, 1'b0, 5'd0, 7'd1, $urandom);
        push_exp(3, 0);
        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);
        n_tests++; if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL error_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs.pop_front();
            n_tests++;
            if (o.err !== e.err || o.ec !== e.ec || o.rid !== e.rid || o.res !== e.res || o.stamp !== e.stamp) begin
                n_fail++;
                $display("FAIL error_beat got err=%b ec=%0d rid=%0d res=%h t=%0d exp err=%b ec=%0d rid=%0d res=%h t=%0d",
                         o.err, o.ec, o.rid, o.res, o.stamp, e.err, e.ec, e.rid, e.res, e.stamp);
            end
        end
        obs.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        for (int s = 0; s < 4; s++) set_src(s, 1'b0, 5'd0, 7'(50 + s), $urandom);
        @(negedge clk);
        idle();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_wb_valid got=%b exp=0", wb_valid); end
        n_tests++; if (wb_robid !== 7'd0) begin n_fail++; $display("FAIL midrst_wb_robid got=%0d exp=0", wb_robid); end
        n_tests++; if (src_ready !== 4'hF) begin n_fail++; $display("FAIL midrst_ready got=%h exp=F", src_ready); end
        @(negedge clk);
        rst = 1'b1;
        obs.delete();
        repeat (5) @(negedge clk);
        n_tests++; if (obs.size() !== 0) begin n_fail++; $display("FAIL midrst_stale_beat got=%0d exp=0", obs.size()); end
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_flush();
        test_error();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
